// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared scoreboard types and constants
package scoreboard_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SHIFT   = 3'd1;
    localparam logic [2:0] ST_CORRECT = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_SHIFT   = ST_SHIFT,
        S_CORRECT = ST_CORRECT,
        S_DONE    = ST_DONE,
        S_ERR     = ST_ERR
    } state_t;

    localparam int BCD_MAX = 9;
    localparam int BIN_W   = 7;
    localparam int N_ITER  = 7;
    localparam int WORK_W  = 8 + BIN_W;

    function automatic logic digit_ok(input logic [3:0] digit);
        return digit <= 4'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_nibble_sub3.sv
// rtl/bcd_nibble_sub3.sv - reverse double-dabble correction for one BCD nibble
module bcd_nibble_sub3 (
    input  logic [3:0] value,
    output logic [3:0] result
);

    // Nibbles >= 8 after a right shift carried a half-ten; remove the excess 3.
    assign result = (value >= 4'd8) ? (value - 4'd3) : value;

endmodule

// File: rtl/decimal_to_bin.sv
// rtl/decimal_to_bin.sv - sequential two-digit BCD to 7-bit binary converter
module decimal_to_bin
    import scoreboard_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] tens_i,
    input  logic [3:0] ones_i,
    output logic       busy_o,
    output logic       valid_o,
    output logic [6:0] bin_o,
    output logic       err_o
);

    state_t              state;
    logic [2:0]          cnt;
    logic [WORK_W-1:0]   work;
    logic [3:0]          tens_fix;
    logic [3:0]          ones_fix;

    bcd_nibble_sub3 u_tens_fix (
        .value  (work[WORK_W-1:WORK_W-4]),
        .result (tens_fix)
    );

    bcd_nibble_sub3 u_ones_fix (
        .value  (work[WORK_W-5:BIN_W]),
        .result (ones_fix)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            work    <= '0;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            bin_o   <= 7'd0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (digit_ok(tens_i) && digit_ok(ones_i)) begin
                            work  <= {tens_i, ones_i, {BIN_W{1'b0}}};
                            cnt   <= 3'd0;
                            state <= S_SHIFT;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                end
                S_SHIFT: begin
                    work <= work >> 1;
                    if (cnt == 3'(N_ITER - 1)) begin
                        state <= S_DONE;
                    end else begin
                        cnt   <= cnt + 3'd1;
                        state <= S_CORRECT;
                    end
                end
                S_CORRECT: begin
                    work  <= {tens_fix, ones_fix, work[BIN_W-1:0]};
                    state <= S_SHIFT;
                end
                S_DONE: begin
                    // BCD field is all-zero here; the low bits hold the result.
                    bin_o   <= work[BIN_W-1:0];
                    valid_o <= 1'b1;
                    busy_o  <= 1'b0;
                    state   <= S_IDLE;
                end
                S_ERR: begin
                    err_o  <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decimal_to_bin.sv
// tb/tb_decimal_to_bin.sv - self-checking bench for decimal_to_bin
module tb_decimal_to_bin;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic       busy;
    logic       valid;
    logic [6:0] bin;
    logic       err;

    int tests = 0;
    int fails = 0;
    int exp_bin = 0;

    decimal_to_bin dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .tens_i  (tens),
        .ones_i  (ones),
        .busy_o  (busy),
        .valid_o (valid),
        .bin_o   (bin),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && busy; k++) @(negedge clk);
        check("idle_reached", int'(busy), 0);
    endtask

    // Leaves the bench at the falling edge right after the accepting edge E0.
    task automatic launch(input int t, input int o);
        wait_idle();
        start = 1'b1;
        tens  = 4'(t);
        ones  = 4'(o);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output int busy_cnt);
        cyc = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (valid) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic count_valids(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (valid) cnt++;
        end
    endtask

    task automatic convert(input int t, input int o, input string tag);
        int cyc, bc, b0;
        launch(t, o);
        b0 = int'(busy);
        wait_valid(cyc, bc);
        exp_bin = 10 * t + o;
        check({tag, "_latency"}, cyc, 14);
        check({tag, "_bin"}, int'(bin), exp_bin);
        check({tag, "_busy_cycles"}, b0 + bc, 14);
        check({tag, "_err"}, int'(err), 0);
    endtask

    task automatic err_case(input int t, input int o);
        launch(t, o);
        check("err_busy_e0", int'(busy), 1);
        check("err_pulse_e0", int'(err), 0);
        @(negedge clk);
        check("err_pulse_e1", int'(err), 1);
        check("err_busy_e1", int'(busy), 0);
        check("err_valid", int'(valid), 0);
        check("err_bin_held", int'(bin), exp_bin);
        @(negedge clk);
        check("err_pulse_clear", int'(err), 0);
        check("err_valid_after", int'(valid), 0);
    endtask

    initial begin
        int cyc, bc, nv, t, o;

        #2 rst = 1'b1;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_bin", int'(bin), 0);
        @(negedge clk);
        rst = 1'b0;

        convert(4, 2, "c42");

        nv = 0;
        for (int tt = 0; tt < 10; tt++) begin
            for (int oo = 0; oo < 10; oo++) begin
                launch(tt, oo);
                wait_valid(cyc, bc);
                if (cyc > 0) nv++;
                check("sweep_bin", int'(bin), 10 * tt + oo);
            end
        end
        exp_bin = 99;
        check("sweep_valid_count", nv, 100);
        check("sweep_last_99", int'(bin), 7'h63);
        convert(0, 0, "c00");

        for (int i = 0; i < 20; i++) begin
            t = int'($urandom_range(0, 9));
            o = int'($urandom_range(0, 9));
            convert(t, o, "rand");
        end

        err_case(10, 3);
        err_case(10, 15);
        err_case(3, 12);
        for (int i = 0; i < 4; i++) begin
            t = int'($urandom_range(10, 15));
            o = int'($urandom_range(0, 15));
            if (i[0]) err_case(o, t);
            else err_case(t, o);
        end

        launch(5, 7);
        repeat (4) @(negedge clk);
        start = 1'b1;
        tens  = 4'd1;
        ones  = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(cyc, bc);
        exp_bin = 57;
        check("ignore_latency", cyc, 9);
        check("ignore_bin", int'(bin), 57);
        count_valids(40, nv);
        check("ignore_no_second_valid", nv, 0);
        check("ignore_bin_held", int'(bin), 57);

        launch(8, 8);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_bin", int'(bin), 0);
        exp_bin = 0;
        @(negedge clk);
        rst = 1'b0;
        count_valids(30, nv);
        check("midrst_no_valid", nv, 0);
        convert(1, 3, "c13");

        wait_idle();
        start = 1'b1;
        tens  = 4'd6;
        ones  = 4'd5;
        wait_valid(cyc, bc);
        check("hold_first_seen", int'(cyc > 0), 1);
        check("hold_first_bin", int'(bin), 65);
        for (int i = 0; i < 3; i++) begin
            wait_valid(cyc, bc);
            check("hold_period", cyc, 15);
            check("hold_bin", int'(bin), 65);
        end
        start = 1'b0;
        exp_bin = 65;
        count_valids(30, nv);
        check("hold_stop", nv, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decimal_to_bin.md
# decimal_to_bin

Sequential BCD-to-binary converter for the scoreboard datapath. It takes a two-digit decimal value (tens digit and ones digit, 0–99) and produces the equivalent 7-bit binary score using the reverse double-dabble (shift-right / subtract-3) algorithm, one operation per clock. It sits between the decimal score-entry logic and the binary score registers, and is the inverse of `bin_to_decimal`. A start/busy/valid handshake makes each conversion an explicit transaction, and invalid BCD digits are rejected with an error pulse.

## Interface
- No parameters. Widths are fixed: two BCD digits in, 7-bit result out, 7 iterations.
- `clk_i` input 1: the single clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous and active-high.
- `start_i` input 1: request a conversion; sampled only when `busy_o`=0.
- `tens_i` input 4: BCD tens digit; legal range 0–9; sampled with `start_i`.
- `ones_i` input 4: BCD ones digit; legal range 0–9; sampled with `start_i`.
- `busy_o` output 1: registered; high while a conversion or error cycle is in progress.
- `valid_o` output 1: registered; one-cycle pulse when `bin_o` has been updated.
- `bin_o` output 7: binary result (0–99); holds its value until the next successful conversion.
- `err_o` output 1: registered; one-cycle pulse when an accepted request had a digit >9.

## Operation
- Working register `work` is 15 bits: `{bcd[7:0], bin[6:0]}`, where `bcd` = `{tens, ones}`.
- FSM states: IDLE, SHIFT, CORRECT, DONE, ERR. Iteration counter `cnt` is 3 bits.
- IDLE behaviour:
  - If `start_i`=1 and both digits are ≤9: load `work` = `{tens_i, ones_i, 7'b0}`, set `cnt`=0, set `busy_o`=1, go to SHIFT.
  - If `start_i`=1 and either digit is >9: set `busy_o`=1, go to ERR. `work` is not loaded.
  - If `start_i`=0: stay in IDLE.
- SHIFT: `work` <= `work >> 1` (logical, MSB filled with 0).
  - If `cnt`==6, go to DONE.
  - Otherwise `cnt`++ and go to CORRECT.
- CORRECT: for each BCD nibble (`work[14:11]`, `work[10:7]`) independently, if nibble ≥8 subtract 3. Then go to SHIFT.
- DONE: `bin_o` <= `work[6:0]`, `valid_o` <= 1, `busy_o` <= 0, go to IDLE.
- ERR: `err_o` <= 1, `busy_o` <= 0, go to IDLE. `bin_o` is unchanged and `valid_o` stays 0.
- `valid_o` and `err_o` are cleared on every cycle other than the one that sets them.
- `start_i` is ignored while `busy_o`=1; there is no queueing.
- Arithmetic:
  - Subtract-3 is applied only to nibbles ≥8, so the result stays within 4 bits with no underflow.
  - The BCD field is all-zero after the final shift.
- Undefined FSM encodings return to IDLE.

## Timing
- Reset values (immediate, asynchronous): state=IDLE, `cnt`=0, `work`=0, `busy_o`=0, `valid_o`=0, `err_o`=0, `bin_o`=0.
- Successful conversion, counting from the edge E0 at which `start_i` is accepted:
  - 7 SHIFT and 6 CORRECT cycles occupy edges E1–E13.
  - DONE executes at E14.
  - `valid_o`=1 and the new `bin_o` are visible in the cycle after E14, i.e. a latency of 14 cycles.
  - `busy_o` is high from after E0 until E14.
- Error path: `err_o` pulses and `busy_o` falls at E1.
- Back-to-back operation: the earliest next accept is at E15, so throughput is one conversion per 15 cycles.
- Reset asserted mid-conversion: the conversion is aborted immediately, all outputs go to reset values, and no `valid_o` is produced after release.
- `start_i` held high continuously: a new conversion is accepted on every IDLE cycle, giving a valid pulse every 15 cycles.

## Structure
- Shared package `scoreboard_pkg` holds:
  - FSM state encoding (3-bit localparams).
  - `BCD_MAX` = 9.
  - `BIN_W` = 7.
  - `N_ITER` = 7.
- Sub-module `bcd_nibble_sub3`: combinational 4-bit-in / 4-bit-out, `in>=8 ? in-3 : in`. It is instantiated twice, in the CORRECT path.
- Everything else is a single sequential always block plus next-state logic in `decimal_to_bin`.

## Test plan
- Reset, then apply tens=4, ones=2, start for 1 cycle -> `busy_o` is high for 14 cycles, then `valid_o` pulses once with `bin_o`=42 (7'h2A) and `err_o`=0.
- Sweep all legal inputs 00–99, each started as soon as IDLE is reached -> each `bin_o` equals 10·tens+ones. Check 0 -> 0 and 99 -> 7'h63; `valid_o` count is 100.
- tens=10 (4'hA), ones=3 -> `err_o` pulses at E1, `busy_o` clears at E1, `valid_o` stays 0, and `bin_o` keeps its previous value. Repeat with ones=15.
- Convert 57, then pulse start with tens=1, ones=1 at E5 -> the second request is ignored; only `bin_o`=57 is reported, and there is no second `valid_o` until a new start is given.
- Convert 88, then assert `rst_i` asynchronously between edges at E7 -> all outputs read 0 immediately. After release there is no `valid_o`; a new request for 13 yields `bin_o`=13.
- Hold `start_i`=1 with tens=6, ones=5 -> `valid_o` pulses every 15 cycles with `bin_o`=65.
